// File: rtl/lift_call_panel.sv
// Request front end for the 3-floor lift: debounces buttons, latches pending calls and
// presents them one at a time, round-robin. Define REQ_TIMEOUT_EN to rotate unserved calls.
module lift_call_panel #(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned TIMEOUT_CYC  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] car_btn,
    input  logic [1:0] hall_up_btn,
    input  logic [1:0] hall_dn_btn,
    input  logic       door,
    input  logic [1:0] flr_rchd,
    output logic [1:0] flr_sel,
    output logic [1:0] up_sel,
    output logic [1:0] down_sel,
    output logic [6:0] call_lamp
);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        GAP
    } state_t;

    localparam logic [7:0] DEB_MAX = 8'(DEBOUNCE_CYC);
    localparam logic [7:0] DEB_PRE = 8'(DEBOUNCE_CYC - 1);

    // Out-of-range parameters leave an obvious marker block in the elaborated hierarchy
    if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > 255 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535)
    begin : g_param_out_of_range
    end

    logic [6:0] raw;
    logic [7:0] cnt_q [7];
    logic [7:0] cnt_d [7];
    logic [6:0] acc_q, acc_d;
    logic [6:0] pend_q, pend_d;
    logic [6:0] clr_mask;
    state_t     state_q, state_d;
    logic [2:0] slot_q, slot_d;
    logic [2:0] ptr_q, ptr_d;
    logic [1:0] flr_q, flr_d;
    logic [1:0] up_q, up_d;
    logic [1:0] dn_q, dn_d;
    logic       pick_found;
    logic [2:0] pick_slot;
    logic [2:0] scan_idx;
`ifdef REQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] to_q, to_d;
`endif

    // Slot order matches the lamp order: car1..car3, up1, up2, dn2, dn3
    assign raw = {hall_dn_btn, hall_up_btn, car_btn};

    function automatic logic [1:0] slot_code(input logic [2:0] s);
        case (s)
            3'd0, 3'd3:       return 2'b01;
            3'd1, 3'd4, 3'd5: return 2'b10;
            default:          return 2'b11;
        endcase
    endfunction

    // Returns {flr_sel, up_sel, down_sel} for a slot
    function automatic logic [5:0] slot_bus(input logic [2:0] s);
        if (s < 3'd3)      return {slot_code(s), 4'b0000};
        else if (s < 3'd5) return {2'b00, slot_code(s), 2'b00};
        else               return {4'b0000, slot_code(s)};
    endfunction

    always_comb begin
        acc_d = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            cnt_d[i] = '0;
            if (raw[i]) begin
                cnt_d[i] = (cnt_q[i] == DEB_MAX) ? cnt_q[i] : cnt_q[i] + 8'd1;
                acc_d[i] = (cnt_q[i] == DEB_PRE);
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        if (door) begin
            case (flr_rchd)
                2'b01:   clr_mask = 7'b0001001;
                2'b10:   clr_mask = 7'b0110010;
                2'b11:   clr_mask = 7'b1000100;
                default: clr_mask = '0;
            endcase
        end
    end

    // Service clear beats a same-cycle accept
    assign pend_d = (pend_q | acc_q) & ~clr_mask;

    always_comb begin
        pick_found = 1'b0;
        pick_slot  = '0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            scan_idx = 3'((32'(ptr_q) + i) % 7);
            if (!pick_found && pend_q[scan_idx]) begin
                pick_found = 1'b1;
                pick_slot  = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        ptr_d   = ptr_q;
        flr_d   = flr_q;
        up_d    = up_q;
        dn_d    = dn_q;
`ifdef REQ_TIMEOUT_EN
        to_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                {flr_d, up_d, dn_d} = '0;
                if (pick_found) begin
                    state_d             = PRESENT;
                    slot_d              = pick_slot;
                    {flr_d, up_d, dn_d} = slot_bus(pick_slot);
                end
            end
            PRESENT: begin
                if (!pend_q[slot_q]) begin
                    state_d             = GAP;
                    ptr_d               = (slot_q == 3'd6) ? 3'd0 : slot_q + 3'd1;
                    {flr_d, up_d, dn_d} = '0;
                end
`ifdef REQ_TIMEOUT_EN
                else if (to_q == TO_LAST) begin
                    state_d             = GAP;
                    ptr_d               = (slot_q == 3'd6) ? 3'd0 : slot_q + 3'd1;
                    {flr_d, up_d, dn_d} = '0;
                end else begin
                    to_d = to_q + 16'd1;
                end
`endif
            end
            GAP: begin
                state_d             = IDLE;
                {flr_d, up_d, dn_d} = '0;
            end
            default: begin
                state_d             = IDLE;
                {flr_d, up_d, dn_d} = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 7; i++) cnt_q[i] <= '0;
            acc_q   <= '0;
            pend_q  <= '0;
            state_q <= IDLE;
            slot_q  <= '0;
            ptr_q   <= '0;
            flr_q   <= '0;
            up_q    <= '0;
            dn_q    <= '0;
`ifdef REQ_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            for (int unsigned i = 0; i < 7; i++) cnt_q[i] <= cnt_d[i];
            acc_q   <= acc_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            slot_q  <= slot_d;
            ptr_q   <= ptr_d;
            flr_q   <= flr_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
`ifdef REQ_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    assign flr_sel   = flr_q;
    assign up_sel    = up_q;
    assign down_sel  = dn_q;
    assign call_lamp = pend_q;

endmodule
